sha1_job_scheduler: RTL

Shares one SHA-1 hash core among NREQ requesters. Arbitrates requests round-robin and launches the core with the winner's message address and size. Waits for the core's done, returns the 160-bit digest to the winner, then pulses the core's reset so the next job starts clean. Sits between the host-side job queues and the single hash core, which keeps its own dpsram port.

---
 rtl/sha1_sched_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/sha1_job_scheduler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sha1_sched_pkg.sv
// Shared types and constants for the SHA-1 job scheduler.
package sha1_sched_pkg;

  localparam int HASH_W = 160;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_CLEAR = 3'd4
  } state_e;

  // Why a job ended; anything other than ERR_NONE is reported as rsp_error.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_REJECT  = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_e;

  // Reference digests: SHA-1("") and SHA-1("abc").
  localparam logic [HASH_W-1:0] DIGEST_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [HASH_W-1:0] DIGEST_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request scanning
// upward from the slot after the last winner.
module rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  // Rotating priority scan; the first hit wins, later hits are ignored.
  always_comb begin
    logic [IDX_W-1:0] jj;
    logic             found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    jj    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      jj = IDX_W'((int'(last) + i) % NREQ);
      if (!found && req[jj]) begin
        found   = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/sha1_job_scheduler.sv
// Shares one SHA-1 core among NREQ requesters: round-robin grant, launch,
// wait for done (or timeout), return the digest, then reset the core.
module sha1_job_scheduler
  import sha1_sched_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int TIMEOUT  = 65535,
  parameter  int CLR_CYC  = 2,
  parameter  int SIZE_MAX = 16384,
  localparam int IDX_W    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_size,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDX_W-1:0]     rsp_id,
  output logic [HASH_W-1:0]    rsp_hash,
  output logic                 rsp_error,
  output logic                 busy,
  output logic                 core_nreset,
  output logic                 core_start,
  output logic [31:0]          core_addr,
  output logic [31:0]          core_size,
  input  logic                 core_done,
  input  logic [HASH_W-1:0]    core_hash
);

  state_e              state_q, state_d;
  err_e                err_q, err_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    id_q, id_d;
  logic [HASH_W-1:0]   hash_q, hash_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         size_q, size_d;
  logic [31:0]         timer_q, timer_d;
  logic                clr_n_q, clr_n_d;

  logic [NREQ-1:0]     gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic [31:0]         sel_addr;
  logic [31:0]         sel_size;
  logic [31:0]         timer_inc;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req  (req_valid),
    .last (last_q),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  // Pick the winner's address/size slice out of the packed request buses.
  always_comb begin
    sel_addr = '0;
    sel_size = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[32*i +: 32];
        sel_size = req_size[32*i +: 32];
      end
    end
  end

  // Next-state logic; timer is shared by WAIT (timeout) and CLEAR (hold count).
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    last_d    = last_q;
    id_d      = id_q;
    hash_d    = hash_q;
    addr_d    = addr_q;
    size_d    = size_q;
    timer_d   = timer_q;
    clr_n_d   = clr_n_q;
    timer_inc = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          last_d = gnt_idx;
          id_d   = gnt_idx;
          addr_d = sel_addr;
          size_d = sel_size;
          if ((sel_addr[31:16] != 16'd0) || (sel_size > 32'(SIZE_MAX))) begin
            err_d   = ERR_REJECT;
            hash_d  = '0;
            state_d = ST_RESP;
          end else begin
            err_d   = ERR_NONE;
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_inc;
        if (core_done) begin
          hash_d  = core_hash;
          err_d   = ERR_NONE;
          state_d = ST_RESP;
        end else if (timer_q == 32'(TIMEOUT - 1)) begin
          hash_d  = '0;
          err_d   = ERR_TIMEOUT;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          // A rejected job never touched the core, so there is nothing to clear.
          if (err_q == ERR_REJECT) begin
            state_d = ST_IDLE;
          end else begin
            timer_d = '0;
            clr_n_d = 1'b0;
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        if (timer_q == 32'(CLR_CYC - 1)) begin
          clr_n_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latch registers; reset leaves requester 0 with first priority.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      last_q  <= IDX_W'(NREQ - 1);
      id_q    <= '0;
      hash_q  <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      timer_q <= '0;
      clr_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      last_q  <= last_d;
      id_q    <= id_d;
      hash_q  <= hash_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      timer_q <= timer_d;
      clr_n_q <= clr_n_d;
    end
  end

  // Accept pulse is the grant itself, so it lands in the grant cycle.
  assign req_ready   = (nreset && state_q == ST_IDLE) ? gnt : '0;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_id      = id_q;
  assign rsp_hash    = hash_q;
  assign rsp_error   = (err_q != ERR_NONE);
  assign busy        = (state_q != ST_IDLE);
  assign core_start  = (state_q == ST_START);
  assign core_addr   = addr_q;
  assign core_size   = size_q;
  // Core resets together with the scheduler, and again after every job.
  assign core_nreset = nreset & clr_n_q;

endmodule
